// File: rtl/mk8_periph_pkg.sv
// mk8_periph_pkg: register word addresses shared by the Mk8 CPU peripheral PIOs
package mk8_periph_pkg;
    typedef logic [2:0] reg_addr_t;
    localparam reg_addr_t ADDR_DATA     = 3'd0;
    localparam reg_addr_t ADDR_RSVD1    = 3'd1;
    localparam reg_addr_t ADDR_IRQMASK  = 3'd2;
    localparam reg_addr_t ADDR_EDGECAP  = 3'd3;
    localparam reg_addr_t ADDR_DEBOUNCE = 3'd4;
    localparam reg_addr_t ADDR_RISE_EN  = 3'd5;
    localparam reg_addr_t ADDR_FALL_EN  = 3'd6;
    localparam reg_addr_t ADDR_RSVD7    = 3'd7;
endpackage

// File: rtl/mk8_tp_gpio_in_if.sv
// mk8_tp_gpio_in_if: Avalon-MM slave bus plus interrupt for the test-point input PIO
interface mk8_tp_gpio_in_if;
    import mk8_periph_pkg::*;
    reg_addr_t   address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/mk8_gpio_debounce_bit.sv
// mk8_gpio_debounce_bit: one input line synchronized and stable-time filtered, with edge pulses
module mk8_gpio_debounce_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  din,
    input  logic [DEBOUNCE_W-1:0] threshold,
    output logic                  db,
    output logic                  rise,
    output logic                  fall
);
    logic [SYNC_STAGES-1:0] sr;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   sync;
    logic                   upd;
    assign sync = sr[SYNC_STAGES-1];
    // >= rather than == so a threshold lowered mid-count releases on the next mismatch
    assign upd  = (sync != db) &&
                  (threshold <= DEBOUNCE_W'(1) || cnt >= threshold - DEBOUNCE_W'(1));
    assign rise = upd & sync;
    assign fall = upd & ~sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            sr  <= {sr[SYNC_STAGES-2:0], din};
            db  <= upd ? sync : db;
            cnt <= (sync == db || upd) ? '0 : cnt + DEBOUNCE_W'(1);
        end
    end
endmodule

// File: rtl/mk8_tp_gpio_in.sv
// mk8_tp_gpio_in: debounced test-point input port with edge capture and masked interrupt
module mk8_tp_gpio_in
    import mk8_periph_pkg::*;
#(
    parameter int                    WIDTH        = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter int                    DEBOUNCE_W   = 16,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_RST = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    mk8_tp_gpio_in_if.slave  bus
);
    logic [WIDTH-1:0]      db, rise, fall;
    logic [WIDTH-1:0]      irq_mask, edge_cap, rise_en, fall_en;
    logic [DEBOUNCE_W-1:0] debounce;
    logic [WIDTH-1:0]      wd, clr;
    logic [31:0]           rd;
    logic                  wr;
    logic                  unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mk8_gpio_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .din       (in_port[i]),
            .threshold (debounce),
            .db        (db[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

    assign wr           = bus.chipselect && !bus.write_n;
    assign wd           = bus.writedata[WIDTH-1:0];
    assign clr          = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;
    assign unused_wdata = ^bus.writedata;
    assign bus.irq      = |(edge_cap & irq_mask);

    always_comb begin
        rd = bus.address == ADDR_DATA     ? 32'(db)       :
             bus.address == ADDR_IRQMASK  ? 32'(irq_mask) :
             bus.address == ADDR_EDGECAP  ? 32'(edge_cap) :
             bus.address == ADDR_DEBOUNCE ? 32'(debounce) :
             bus.address == ADDR_RISE_EN  ? 32'(rise_en)  :
             bus.address == ADDR_FALL_EN  ? 32'(fall_en)  : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            rise_en      <= '0;
            fall_en      <= '0;
            debounce     <= DEBOUNCE_RST;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == ADDR_IRQMASK)  irq_mask <= wd;
            if (wr && bus.address == ADDR_DEBOUNCE) debounce <= bus.writedata[DEBOUNCE_W-1:0];
            if (wr && bus.address == ADDR_RISE_EN)  rise_en  <= wd;
            if (wr && bus.address == ADDR_FALL_EN)  fall_en  <= wd;
            // a fresh edge overrides a same-cycle write-1-to-clear
            edge_cap     <= (edge_cap & ~clr) | (rise & rise_en) | (fall & fall_en);
            bus.readdata <= rd;
        end
    end
endmodule

// File: tb/tb_mk8_tp_gpio_in.sv
// tb_mk8_tp_gpio_in: register table, directed debounce/capture sequences and randomized model comparison
module tb_mk8_tp_gpio_in;
    localparam int S = 2;
    localparam logic [31:0] DB_RST = 32'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_port = '0;
    int         checks = 0;
    int         failures = 0;

    mk8_tp_gpio_in_if bus();

    mk8_tp_gpio_in #(
        .WIDTH        (8),
        .SYNC_STAGES  (S),
        .DEBOUNCE_W   (16),
        .DEBOUNCE_RST (16'd3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    // reference: db flips once the last N synchronized samples all disagree with it
    logic [7:0] m_db, m_ecap, m_rise, m_fall, m_mask;
    int         m_n;
    logic [7:0] hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        tick();
        check(name, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic reset_reads;
        for (int a = 0; a < 8; a++)
            rd_chk($sformatf("reset_rd%0d", a), 3'(a), a == 4 ? DB_RST : 32'd0);
        check("reset_irq", 32'(bus.irq), 32'd0);
    endtask

    task automatic scenario_rise;
        wr(3'd4, 32'd0);
        wr(3'd5, 32'hFF);
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        tick();
        tick();
        check("rise_irq_early", 32'(bus.irq), 32'd0);
        tick();
        check("rise_irq_3clk", 32'(bus.irq), 32'd1);
        rd_chk("rise_data", 3'd0, 32'h01);
        rd_chk("rise_ecap", 3'd3, 32'h01);
        wr(3'd3, 32'h01);
        check("w1c_irq", 32'(bus.irq), 32'd0);
        rd_chk("w1c_ecap", 3'd3, 32'h00);
    endtask

    task automatic step_model;
        logic [7:0] nd;
        logic       all;
        hist.push_back(in_port);
        nd = m_db;
        for (int b = 0; b < 8; b++) begin
            all = 1'b1;
            for (int j = 0; j < m_n; j++)
                if (hist[hist.size() - 1 - S - j][b] == m_db[b]) all = 1'b0;
            if (all) nd[b] = ~m_db[b];
        end
        m_ecap = m_ecap | (nd & ~m_db & m_rise) | (~nd & m_db & m_fall);
        m_db = nd;
    endtask

    initial begin
        logic [7:0]  pdb, pec;
        logic [2:0]  a;
        logic [31:0] dbv;
        int          k;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        reset_reads();

        vecs[0] = '{3'd2, 32'hFFFF_FF5A, 32'h5A};
        vecs[1] = '{3'd4, 32'h0001_2345, 32'h2345};
        vecs[2] = '{3'd5, 32'hFFFF_FF3C, 32'h3C};
        vecs[3] = '{3'd6, 32'h0000_0181, 32'h81};
        vecs[4] = '{3'd0, 32'h0000_00FF, 32'h00};
        vecs[5] = '{3'd1, 32'h0000_00FF, 32'h00};
        vecs[6] = '{3'd7, 32'h0000_00FF, 32'h00};
        vecs[7] = '{3'd3, 32'h0000_00FF, 32'h00};
        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd_chk($sformatf("tbl%0d", i), vecs[i].addr, vecs[i].exp);
        end

        scenario_rise();

        wr(3'd4, 32'd10);
        wr(3'd2, 32'h08);
        in_port = 8'h09;
        repeat (9) tick();
        in_port = 8'h01;
        repeat (15) tick();
        check("glitch_irq", 32'(bus.irq), 32'd0);
        rd_chk("glitch_data", 3'd0, 32'h01);
        rd_chk("glitch_ecap", 3'd3, 32'h00);
        in_port = 8'h09;
        k = 1;
        while (k <= 40) begin
            tick();
            if (bus.irq) break;
            k++;
        end
        check("hold_latency", 32'(k), 32'(S + 10));
        rd_chk("hold_data", 3'd0, 32'h09);
        wr(3'd3, 32'hFF);

        wr(3'd4, 32'd0);
        wr(3'd5, 32'h00);
        wr(3'd6, 32'h04);
        wr(3'd2, 32'h00);
        in_port = 8'h0D;
        repeat (5) tick();
        rd_chk("fall_only_rise", 3'd3, 32'h00);
        in_port = 8'h09;
        repeat (5) tick();
        rd_chk("fall_only_fall", 3'd3, 32'h04);
        check("fall_masked_irq", 32'(bus.irq), 32'd0);

        wr(3'd6, 32'h05);
        in_port = 8'h08;
        tick();
        tick();
        wr(3'd3, 32'h05);
        rd_chk("set_beats_clear", 3'd3, 32'h01);

        wr(3'd5, 32'hFF);
        wr(3'd6, 32'hFF);
        wr(3'd2, 32'hFF);
        in_port = 8'hF7;
        repeat (4) tick();
        rd_chk("all_edges", 3'd3, 32'hFF);
        wr(3'd4, 32'd10);
        in_port = 8'h08;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("rst_irq_now", 32'(bus.irq), 32'd0);
        check("rst_rdata_now", bus.readdata, 32'd0);
        tick();
        tick();
        in_port = 8'h00;
        reset_n = 1'b1;
        reset_reads();
        scenario_rise();

        for (int r = 0; r < 3; r++) begin
            in_port = 8'h00;
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            tick();
            dbv    = 32'($urandom_range(0, 4));
            m_n    = dbv == 0 ? 1 : int'(dbv);
            m_rise = 8'($urandom);
            m_fall = 8'($urandom);
            m_mask = 8'($urandom);
            wr(3'd4, dbv);
            wr(3'd5, 32'(m_rise));
            wr(3'd6, 32'(m_fall));
            wr(3'd2, 32'(m_mask));
            m_db   = '0;
            m_ecap = '0;
            hist.delete();
            for (int j = 0; j < S + 4; j++) hist.push_back(8'h00);
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom & $urandom);
                a = (i % 2 == 1) ? 3'd3 : 3'd0;
                bus.address = a;
                pdb = m_db;
                pec = m_ecap;
                step_model();
                tick();
                check(a == 3'd0 ? "rnd_data" : "rnd_ecap", bus.readdata, 32'(a == 3'd0 ? pdb : pec));
                check("rnd_irq", 32'(bus.irq), 32'(|(m_ecap & m_mask)));
            end
            bus.chipselect = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
